six_bit_divider: RTL and testbench
==================================

SIX_BIT_DIVIDER -- requirements
Module: six_bit_divider

Interface
REQ-001 SHALL have parameter W, default 6, giving divisor/quotient/remainder width; dividend width is 2*W.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port dividend  input  2*W  numerator, unsigned; sampled on accept.
REQ-007 SHALL have port divisor  input  W  denominator, unsigned; sampled on accept.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  W  unsigned quotient.
REQ-011 SHALL have port remainder  output  W  unsigned remainder.
REQ-012 SHALL have port div_zero  output  1  divisor was zero.
REQ-013 SHALL have port overflow  output  1  quotient does not fit in W bits (divisor nonzero).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept occurs when in_valid && in_ready.
REQ-016 On accept with divisor==0: SHALL go to DONE next cycle with div_zero=1, overflow=0, quotient=all ones, remainder=0.
REQ-017 On accept with divisor!=0 and dividend[2W-1:W] >= divisor: SHALL go to DONE next cycle with overflow=1, div_zero=0, quotient=all ones, remainder=0.
REQ-018 Otherwise SHALL load partial remainder = dividend[2W-1:W], shift register = dividend[W-1:0], step counter = 0, and enter BUSY.
REQ-019 In BUSY, each cycle SHALL form t = {partial, next MSB of shift register} (W+1 bits); if t >= divisor, partial = t - divisor and quotient bit = 1, else partial = t[W-1:0] and bit = 0; quotient bits enter LSB-first-shifted (MSB resolved first).
REQ-020 BUSY SHALL last exactly W cycles; after the W-th step FSM SHALL enter DONE.
REQ-021 Normal-path latency: out_valid SHALL rise W+1 cycles after the accept edge; error paths SHALL have latency 1.
REQ-022 In DONE out_valid=1; quotient, remainder, div_zero, overflow SHALL be stable while out_valid && !out_ready.
REQ-023 On out_valid && out_ready SHALL return to IDLE next cycle; in_ready SHALL not be asserted in the same cycle (no accept/deliver overlap).
REQ-024 For non-error results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor.
REQ-025 in_valid, dividend, divisor changes outside the accept cycle SHALL have no effect.
REQ-026 out_ready while not in DONE SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0, counter=0.
REQ-028 Reset asserted in BUSY or DONE SHALL abandon the operation; no result SHALL be delivered afterward.
REQ-029 After rst_n deasserts, first accept SHALL be possible in the first cycle.

Structure
REQ-030 Shared package kyber_arith_pkg SHALL hold the FSM state typedef and the default width constant W=6.
REQ-031 One combinational sub-module div_step_unit SHALL implement the REQ-019 compare/subtract step (inputs partial, next bit, divisor; outputs new partial, quotient bit).
REQ-032 No multiplier, divider operator, or memory SHALL be inferred; only one W+1-bit subtractor.

Verification
REQ-033 dividend=2015, divisor=63 -> after 7 cycles quotient=31, remainder=62, flags 0.
REQ-034 dividend=4031, divisor=63 -> quotient=63, remainder=62, flags 0; dividend=0, divisor=1 -> quotient=0, remainder=0.
REQ-035 dividend=4095, divisor=63 -> next cycle out_valid, overflow=1, quotient=63, remainder=0; dividend=100, divisor=0 -> div_zero=1.
REQ-036 dividend=200, divisor=7 with out_ready low 3 cycles -> quotient=28, remainder=4 held stable; in_ready low until one cycle after handshake.
REQ-037 rst_n pulsed low during 3rd BUSY cycle -> out_valid never rises; new op 35/5 then yields quotient=7, remainder=0.
REQ-038 Random 10k ops vs reference model incl. back-pressure -> REQ-024 holds, flags match.

Source files
------------

// File: rtl/kyber_arith_pkg.sv
// Shared arithmetic definitions: divider FSM state encoding and default width.
package kyber_arith_pkg;

  // Default divisor / quotient / remainder width; the dividend is twice this.
  localparam int unsigned DEFAULT_W = 6;

  // Divider FSM state type with legacy-compatible constant encodings.
  typedef logic [1:0] div_state_t;

  localparam div_state_t ST_IDLE = 2'd0;
  localparam div_state_t ST_BUSY = 2'd1;
  localparam div_state_t ST_DONE = 2'd2;

endpackage : kyber_arith_pkg

// File: rtl/div_step_unit.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step_unit #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] partial,
  input  logic         next_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] new_partial,
  output logic         q_bit
);

  logic [W:0] t;
  logic [W:0] diff;
  logic       borrow;
  logic       fits;

  assign t = {partial, next_bit};

  // The single subtractor; its carry-out is the borrow that decides the bit.
  assign {borrow, diff} = {1'b0, t} - {2'b0, divisor};

  // Without a borrow, t - divisor < divisor, so diff[W] is always 0 here;
  // folding it in keeps the full subtractor result consumed.
  assign fits = ~borrow & ~diff[W];

  assign q_bit       = fits;
  assign new_partial = fits ? diff[W-1:0] : t[W-1:0];

endmodule : div_step_unit

// File: rtl/six_bit_divider.sv
// Sequential unsigned 2W/W restoring divider with valid/ready handshakes on
// both sides. Divide-by-zero and quotient overflow are detected at accept and
// reported after one cycle; otherwise the quotient is resolved MSB first over
// W cycles.
module six_bit_divider
  import kyber_arith_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  div_state_t  state;
  logic [W-1:0] partial;     // partial remainder, final remainder in DONE
  logic [W-1:0] shreg;       // dividend low half in, quotient bits out
  logic [W-1:0] divisor_q;   // divisor captured at accept
  logic [CW-1:0] step_cnt;
  logic         div_zero_q;
  logic         overflow_q;

  logic [W-1:0] hi_half;
  logic [W-1:0] lo_half;
  logic [W-1:0] step_partial;
  logic         step_bit;
  logic         accept;

  assign hi_half = dividend[2*W-1:W];
  assign lo_half = dividend[W-1:0];
  assign accept  = in_valid && (state == ST_IDLE);

  div_step_unit #(
    .W (W)
  ) u_step (
    .partial     (partial),
    .next_bit    (shreg[W-1]),
    .divisor     (divisor_q),
    .new_partial (step_partial),
    .q_bit       (step_bit)
  );

  // FSM and datapath: capture at accept, one step per BUSY cycle, hold in DONE.
  // NOTE: every register here uses <= so all next-state values are computed
  // from the pre-edge values; blocking = would chain the steps within a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      partial    <= '0;
      shreg      <= '0;
      divisor_q  <= '0;
      step_cnt   <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            divisor_q <= divisor;
            step_cnt  <= '0;
            if (divisor == '0) begin
              state      <= ST_DONE;
              shreg      <= '1;
              partial    <= '0;
              div_zero_q <= 1'b1;
              overflow_q <= 1'b0;
            end else if (hi_half >= divisor) begin
              state      <= ST_DONE;
              shreg      <= '1;
              partial    <= '0;
              div_zero_q <= 1'b0;
              overflow_q <= 1'b1;
            end else begin
              state      <= ST_BUSY;
              partial    <= hi_half;
              shreg      <= lo_half;
              div_zero_q <= 1'b0;
              overflow_q <= 1'b0;
            end
          end
        end

        ST_BUSY: begin
          partial  <= step_partial;
          shreg    <= {shreg[W-2:0], step_bit};
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == LAST_STEP) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign quotient  = shreg;
  assign remainder = partial;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule : six_bit_divider

// File: tb/tb_six_bit_divider.sv
// Directed bench for six_bit_divider: reset values, normal and error paths,
// latency, back-pressure hold, mid-operation reset and a seeded random sweep.
module tb_six_bit_divider;

  localparam int W = 6;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  int n_checks;
  int n_pass;

  six_bit_divider #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one operation, measure latency, optionally stall, then hand it off.
  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov, input int elat,
                        input int hold, input logic early);
    int lat;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = d;
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 12'($urandom);
    divisor  = 6'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        check("hold_valid", out_valid, 1);
        check("hold_quot", quotient, eq);
        check("hold_rem", remainder, er);
        check("hold_in_ready", in_ready, 0);
        @(negedge clk);
      end
    end
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, edz);
    check("overflow", overflow, eov);
    check("in_ready_at_handshake", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  initial begin
    logic [2*W-1:0] a;
    logic [W-1:0]   d;
    logic [W-1:0]   eq;
    logic [W-1:0]   er;
    logic           edz;
    logic           eov;
    int             elat;
    logic           seen;

    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    run_op(12'd2015, 6'd63, 6'd31, 6'd62, 1'b0, 1'b0, W + 1, 0, 1'b0);
    run_op(12'd4031, 6'd63, 6'd63, 6'd62, 1'b0, 1'b0, W + 1, 0, 1'b0);
    run_op(12'd0,    6'd1,  6'd0,  6'd0,  1'b0, 1'b0, W + 1, 0, 1'b1);
    run_op(12'd4095, 6'd63, 6'd63, 6'd0,  1'b0, 1'b1, 1,     0, 1'b0);
    run_op(12'd100,  6'd0,  6'd63, 6'd0,  1'b1, 1'b0, 1,     0, 1'b0);
    run_op(12'd200,  6'd7,  6'd28, 6'd4,  1'b0, 1'b0, W + 1, 3, 1'b0);
    run_op(12'd64,   6'd1,  6'd63, 6'd0,  1'b0, 1'b1, 1,     1, 1'b0);
    run_op(12'd63,   6'd1,  6'd63, 6'd0,  1'b0, 1'b0, W + 1, 0, 1'b0);

    // Reset during the third BUSY cycle abandons the operation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 12'd200;
    divisor  = 6'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_result_after_reset", seen, 0);
    run_op(12'd35, 6'd5, 6'd7, 6'd0, 1'b0, 1'b0, W + 1, 0, 1'b0);

    // Seeded random sweep against a behavioural reference.
    for (int i = 0; i < 300; i++) begin
      d = 6'($urandom_range(0, 63));
      if (i % 17 == 0) d = '0;
      if (d != 0 && (i % 2 == 0)) a = 12'($urandom_range(0, int'(d) * 64 - 1));
      else a = 12'($urandom_range(0, 4095));
      if (d == 0) begin
        eq = '1; er = '0; edz = 1'b1; eov = 1'b0; elat = 1;
      end else if ((a >> W) >= 12'(d)) begin
        eq = '1; er = '0; edz = 1'b0; eov = 1'b1; elat = 1;
      end else begin
        eq = 6'(a / 12'(d)); er = 6'(a % 12'(d)); edz = 1'b0; eov = 1'b0; elat = W + 1;
      end
      run_op(a, d, eq, er, edz, eov, elat, $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_six_bit_divider
